// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit, common-anode
// seven-segment display. It shows a 32-bit word as 8 hex digits, scanning one
// digit every REFRESH_DIV clocks.
//
// The displayed word is captured once per frame, at the digit-7 -> digit-0
// wrap, unless hold is high. A frame therefore never mixes old and new data.
// The decimal point of digit 0 lights while a held frame is being shown.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits. Digit 0 is never blanked.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        hold,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // A width of at least 1 keeps REFRESH_DIV == 1 legal.
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler_r;
  logic [PW-1:0] prescaler_next_s;
  logic          tick_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_next_s;
  logic [31:0]   snapshot_r;
  logic [31:0]   snapshot_next_s;
  logic [3:0]    nibble_s;
  logic [7:0]    an_next_s;
  logic [6:0]    seg_next_s;
  logic          dp_next_s;

  // Map a hex nibble to its active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      4'hF:    code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Report whether digit k is a leading zero, meaning nibbles k..7 are all zero.
  // Digit 0 is never treated as a leading zero.
  function automatic logic is_leading_zero(input logic [31:0] word, input logic [2:0] k);
    return (k != 3'd0) && ((word >> {k, 2'b00}) == 32'h0000_0000);
  endfunction
`endif

  // Compute the next prescaler, digit index, snapshot and output values.
  always_comb begin
    prescaler_next_s = prescaler_r;
    idx_next_s       = idx_r;
    snapshot_next_s  = snapshot_r;
    an_next_s        = an;
    seg_next_s       = seg;
    dp_next_s        = dp;
    nibble_s         = 4'h0;

    tick_s = (prescaler_r == PS_LAST);

    if (tick_s) begin
      prescaler_next_s = {PW{1'b0}};
      idx_next_s       = idx_r + 3'd1;
    end else begin
      prescaler_next_s = prescaler_r + PW'(1);
      idx_next_s       = idx_r;
    end

    // The word is captured only at the frame wrap, so a frame is never torn.
    if (tick_s && (idx_r == 3'd7) && !hold) begin
      snapshot_next_s = value;
    end else begin
      snapshot_next_s = snapshot_r;
    end

    nibble_s = snapshot_next_s[{idx_next_s, 2'b00} +: 4];

    // Outputs change only on a digit step. Otherwise dp would follow hold mid-frame.
    if (tick_s) begin
      an_next_s = ~(8'd1 << idx_next_s);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (is_leading_zero(snapshot_next_s, idx_next_s)) begin
        seg_next_s = 7'h7F;
      end else begin
        seg_next_s = seg_decode(nibble_s);
      end
`else
      seg_next_s = seg_decode(nibble_s);
`endif
      dp_next_s = ~((idx_next_s == 3'd0) && hold);
    end else begin
      an_next_s  = an;
      seg_next_s = seg;
      dp_next_s  = dp;
    end
  end

  // Update the scan state and the output registers. Reset shows digit 0 of a zero word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_r <= {PW{1'b0}};
      idx_r       <= 3'd0;
      snapshot_r  <= 32'h0000_0000;
      an          <= 8'hFE;
      seg         <= 7'h40;
      dp          <= 1'b1;
    end else begin
      prescaler_r <= prescaler_next_s;
      idx_r       <= idx_next_s;
      snapshot_r  <= snapshot_next_s;
      an          <= an_next_s;
      seg         <= seg_next_s;
      dp          <= dp_next_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver. It runs two instances side by side, with
// REFRESH_DIV = 4 and REFRESH_DIV = 1, on shared inputs.
//
// A reference model derives the expected display from the number of clocks
// elapsed since reset:
//   tick number = cycles / div
//   digit       = tick number mod 8
// The word and hold are captured when the digit count returns to 0.
module tb_seg7_scan_driver;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [7:0] F1_AN  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  localparam logic [6:0] F1_SEG [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        hold;
  logic [7:0]  an4, an1;
  logic [6:0]  seg4, seg1;
  logic        dp4, dp1;

  int          n_cmp;
  int          n_bad;
  bit          chk_en;

  // Model state, indexed per instance: 0 -> div 4, 1 -> div 1.
  int          m_cyc  [2];
  int          m_dig  [2];
  logic [31:0] m_snap [2];
  bit          m_hw   [2];

  seg7_scan_driver #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .value(value), .hold(hold), .an(an4), .seg(seg4), .dp(dp4)
  );
  seg7_scan_driver #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .value(value), .hold(hold), .an(an1), .seg(seg1), .dp(dp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_an(input int d);
    logic [7:0] r;
    r = 8'hFF;
    r[d] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] s, input int d);
    logic [31:0] sh;
    sh = s >> (4 * d);
    if (BLANK && d != 0 && sh == 32'h0) return 7'h7F;
    return SEG_TBL[sh[3:0]];
  endfunction

  task automatic model_reset(input int i);
    m_cyc[i]  = 0;
    m_dig[i]  = 0;
    m_snap[i] = 32'h0;
    m_hw[i]   = 1'b0;
  endtask

  task automatic model_step(input int i, input int div);
    m_cyc[i]++;
    if (m_cyc[i] % div == 0) begin
      m_dig[i] = (m_cyc[i] / div) % 8;
      if (m_dig[i] == 0) begin
        if (!hold) m_snap[i] = value;
        m_hw[i] = hold;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset(0);
    else      model_step(0, 4);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset(1);
    else      model_step(1, 1);
  end

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("an4", an4, exp_an(m_dig[0]));
      check_val("seg4", seg4, exp_seg(m_snap[0], m_dig[0]));
      check_val("dp4", dp4, (m_dig[0] == 0 && m_hw[0]) ? 1'b0 : 1'b1);
      check_val("an1", an1, exp_an(m_dig[1]));
      check_val("seg1", seg1, exp_seg(m_snap[1], m_dig[1]));
      check_val("dp1", dp1, (m_dig[1] == 0 && m_hw[1]) ? 1'b0 : 1'b1);
    end
  end

  task automatic wait_dig4(input int d);
    int k;
    k = 0;
    while (m_dig[0] != d && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("wait_dig", (m_dig[0] == d) ? 1 : 0, 1);
  endtask

  initial begin
    int k;
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    rst    = 1'b0;
    value  = 32'h12345678;
    hold   = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_val("rst_an", an4, 8'hFE);
    check_val("rst_seg", seg4, 7'h40);
    check_val("rst_dp", dp4, 1'b1);
    rst = 1'b1;

    // The first frame shows the zero word captured at reset.
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      if (c % 4 == 2) check_val("f0_seg", seg4, (BLANK && (c / 4) != 0) ? 7'h7F : 7'h40);
    end
    @(negedge clk);
    // The second frame shows 12345678.
    for (int i = 0; i < 8; i++) begin
      check_val("f1_an", an4, F1_AN[i]);
      check_val("f1_seg", seg4, F1_SEG[i]);
      repeat (4) @(negedge clk);
    end

    // A value change mid-frame waits for the wrap.
    wait_dig4(3);
    #1 value = 32'hFFFFFFFF;
    wait_dig4(4);
    check_val("old_nib4", seg4, 7'h19);
    wait_dig4(0);
    check_val("new_d0", seg4, 7'h0E);

    // Hold across a wrap, then release it.
    wait_dig4(5);
    #1 hold = 1'b1;
    value = 32'hA5A5A5A5;
    wait_dig4(0);
    check_val("hold_d0_dp", dp4, 1'b0);
    check_val("hold_d0_seg", seg4, 7'h0E);
    wait_dig4(1);
    check_val("hold_d1_dp", dp4, 1'b1);
    check_val("hold_d1_seg", seg4, 7'h0E);
    wait_dig4(6);
    #1 hold = 1'b0;
    wait_dig4(0);
    check_val("rel_d0_seg", seg4, 7'h12);
    check_val("rel_d0_dp", dp4, 1'b1);
    wait_dig4(1);
    check_val("rel_d1_seg", seg4, 7'h08);

    // Leading zeros in a small word.
    #1 value = 32'h000000A0;
    wait_dig4(0);
    check_val("lz_d0", seg4, 7'h40);
    wait_dig4(1);
    check_val("lz_d1", seg4, 7'h08);
    wait_dig4(2);
    check_val("lz_d2", seg4, BLANK ? 7'h7F : 7'h40);
    wait_dig4(7);
    check_val("lz_d7", seg4, BLANK ? 7'h7F : 7'h40);

    // Asynchronous reset pulse between clock edges.
    wait_dig4(5);
    #2 rst = 1'b0;
    #1;
    check_val("arst_an", an4, 8'hFE);
    check_val("arst_seg", seg4, 7'h40);
    check_val("arst_dp", dp4, 1'b1);
    check_val("arst_an1", an1, 8'hFE);
    #1 rst = 1'b1;
    wait_dig4(3);
    check_val("arst_snap0", seg4, BLANK ? 7'h7F : 7'h40);

    // REFRESH_DIV == 1 rotates every cycle.
    k = 0;
    while (an1 !== 8'h7F && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("div1_sync", an1, 8'h7F);
    @(negedge clk);
    check_val("div1_wrap", an1, 8'hFE);
    @(negedge clk);
    check_val("div1_next", an1, 8'hFD);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) value = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) hold = ~hold;
      if ($urandom_range(0, 999) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
